// File: rtl/df_serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// df_pkg
// Shared definitions for the bit-serial add/subtract controller:
//   - state_e     : controller FSM states (IDLE, RUN, DONE)
//   - cnt_width() : bit-counter width for a given operand width ($clog2(WIDTH))
//   - sat_max()   : bit pattern of the largest positive value, 2^(w-1)-1
//   - sat_min()   : bit pattern of the most negative value, -2^(w-1)
// The saturation helpers return 64-bit patterns; callers slice off the low
// WIDTH bits. Operand widths up to 64 bits are supported by these helpers.
// -----------------------------------------------------------------------------
package df_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // -2^(w-1) in w-bit two's complement is a lone 1 in the sign position.
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/df_fulladder.sv
// -----------------------------------------------------------------------------
// df_fulladder
// Single-bit full adder used as the time-shared datapath of the serial
// add/subtract controller.
// Ports:
//   a_i, b_i  : addend bits
//   ci_i      : carry in
//   s_o       : sum bit
//   co_o      : carry out
// -----------------------------------------------------------------------------
module df_fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/df_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// df_serial_add_ctrl
// Bit-serial add/subtract controller. One df_fulladder is time-shared over
// WIDTH-bit operands, LSB first, one bit per clock.
//
// Parameters:
//   WIDTH    : operand/result width in bits (>= 2)
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start_i  : request a new operation (only honoured in IDLE)
//   a_i, b_i : operands, captured on an accepted start
//   sub_i    : 0 = A+B, 1 = A-B, captured on an accepted start
//   busy_o   : high in RUN and DONE
//   done_o   : one-cycle pulse, result valid
//   sum_o    : result, held until the next done_o
//   carry_o  : carry out of the MSB (subtract: 1 = no borrow)
//   ovf_o    : signed overflow
//
// Optional feature (macro DF_SERIAL_SAT_EN): on signed overflow the result is
// replaced by the saturation limit selected by the sign of operand A.
//
// Timing: start accepted at edge T -> WIDTH RUN cycles -> DONE cycle, during
// which done_o is high and sum_o/carry_o/ovf_o show the new result.
// -----------------------------------------------------------------------------
module df_serial_add_ctrl
  import df_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int              CNT_W   = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ci_msb_q, ci_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;
  logic             ovf_now;
  logic [WIDTH-1:0] result_now;

  df_fulladder u_fa (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf_now = ci_msb_q ^ carry_q;

`ifdef DF_SERIAL_SAT_EN
  localparam logic [63:0]      SAT_MAX_FULL = sat_max(WIDTH);
  localparam logic [63:0]      SAT_MIN_FULL = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];

  // The A register is shifted away during RUN, so its original sign bit is
  // kept separately to pick the saturation direction.
  logic a_msb_q, a_msb_d;

  always_comb begin
    a_msb_d = a_msb_q;
    if (state_q == IDLE && start_i) begin
      a_msb_d = a_i[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
    end
  end

  always_comb begin
    result_now = res_q;
    if (ovf_now) begin
      result_now = a_msb_q ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign result_now = res_q;
`endif

  // Next-state and datapath sequencing.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    ci_msb_d    = ci_msb_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Subtraction as A + ~B + 1: the +1 enters as the initial carry.
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Carry currently held is the carry into the MSB position.
          ci_msb_d = carry_q;
          state_d  = DONE;
        end
      end

      DONE: begin
        sum_d       = result_now;
        carry_out_d = carry_q;
        ovf_d       = ovf_now;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      ci_msb_q    <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      ci_msb_q    <= ci_msb_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
    end
  end

  // During DONE the fresh result is forwarded so it is valid alongside
  // done_o; afterwards the registered copy holds it stable.
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign sum_o   = done_o ? result_now : sum_q;
  assign carry_o = done_o ? carry_q    : carry_out_q;
  assign ovf_o   = done_o ? ovf_now    : ovf_q;

endmodule

// File: tb/tb_df_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_df_serial_add_ctrl
// Self-checking bench for df_serial_add_ctrl (WIDTH = 8). A behavioural model
// computes each result with integer arithmetic and tracks the busy/done
// window; a negedge process compares every DUT output against it each cycle.
// Directed vectors additionally pin literal results, latency and reset.
// -----------------------------------------------------------------------------
module tb_df_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         sub_i = 1'b0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         carry_o;
  logic         ovf_o;

  int checks = 0;
  int errors = 0;

  df_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .sub_i   (sub_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  // Reference arithmetic from integer values.
  function automatic res_t model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub);
    res_t r;
    int sa, sb, sres;
    int unsigned ua, ub, ures;
    sa = $signed(a);
    sb = $signed(b);
    sres = sub ? (sa - sb) : (sa + sb);
    ua = a;
    ub = b;
    ures = sub ? (ua + ((1 << W) - 1 - ub) + 1) : (ua + ub);
    r.carry = ures[W];
    r.ovf   = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
    r.sum   = ures[W-1:0];
`ifdef DF_SERIAL_SAT_EN
    if (r.ovf) begin
      r.sum = a[W-1] ? W'(1 << (W - 1)) : W'((1 << (W - 1)) - 1);
    end
`endif
    return r;
  endfunction

  // Model of the handshake: rem counts the busy cycles still to come.
  int   rem = 0;
  res_t cur = '0;
  res_t hold = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= 0;
      cur  <= '0;
      hold <= '0;
    end else if (rem == 0) begin
      if (start_i) begin
        rem <= W + 1;
        cur <= model_op(a_i, b_i, sub_i);
      end
    end else begin
      if (rem == 1) hold <= cur;
      rem <= rem - 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic         e_busy, e_done;
    res_t         e;
    e_busy = (rem > 0);
    e_done = (rem == 1);
    e      = e_done ? cur : hold;
    checks++;
    if (busy_o !== e_busy || done_o !== e_done || sum_o !== e.sum ||
        carry_o !== e.carry || ovf_o !== e.ovf) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got busy=%b done=%b sum=%h c=%b v=%b, want busy=%b done=%b sum=%h c=%b v=%b",
               $time, busy_o, done_o, sum_o, carry_o, ovf_o,
               e_busy, e_done, e.sum, e.carry, e.ovf);
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Issue one operation and wait for done_o. lat = edges from raising start_i
  // until done_o is visible; bsy = cycles busy_o was seen high meanwhile.
  // noise=1 toggles start_i and operands while the operation is running.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input bit noise, output int lat, output int bsy);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    a_i = a;
    b_i = b;
    sub_i = sub;
    lat = 0;
    bsy = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (busy_o) bsy++;
      start_i = 1'b0;
      if (noise && lat < W) begin
        start_i = 1'($urandom_range(0, 1));
        a_i     = W'($urandom);
        b_i     = W'($urandom);
        sub_i   = 1'($urandom_range(0, 1));
      end
    end while (!done_o && lat < 40);
    start_i = 1'b0;
    checks++;
    if (!done_o) begin
      errors++;
      $display("FAIL done_timeout got=no_done want=done_within_40");
    end
    $display("op a=%h b=%h sub=%b -> sum=%h carry=%b ovf=%b lat=%0d",
             a, b, sub, sum_o, carry_o, ovf_o, lat);
  endtask

  initial begin
    int lat, bsy, gap, dones;
    logic [W-1:0] sat_pos, sat_neg, exp_s;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_sum", sum_o, 0);
    check("reset_carry_ovf", {carry_o, ovf_o}, 0);
    rst_n = 1'b1;

    // Directed vectors with literal expectations.
    run_op(8'h35, 8'h4A, 1'b0, 1'b0, lat, bsy);
    check("lat_35_4a", lat, 9);
    check("busy_35_4a", bsy, 9);
    check("sum_35_4a", sum_o, 8'h7F);
    check("cv_35_4a", {carry_o, ovf_o}, 2'b00);

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, bsy);
    check("sum_ff_01", sum_o, 8'h00);
    check("cv_ff_01", {carry_o, ovf_o}, 2'b10);

    run_op(8'h10, 8'h20, 1'b1, 1'b0, lat, bsy);
    check("sum_10_m_20", sum_o, 8'hF0);
    check("c_10_m_20", carry_o, 0);

    run_op(8'h20, 8'h10, 1'b1, 1'b0, lat, bsy);
    check("sum_20_m_10", sum_o, 8'h10);
    check("c_20_m_10", carry_o, 1);

    sat_pos = 8'h7F;
    sat_neg = 8'h80;
`ifdef DF_SERIAL_SAT_EN
    exp_s = sat_pos;
`else
    exp_s = sat_neg;
`endif
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, lat, bsy);
    check("ovf_7f_01", ovf_o, 1);
    check("sum_7f_01", sum_o, exp_s);
`ifdef DF_SERIAL_SAT_EN
    exp_s = sat_neg;
`else
    exp_s = sat_pos;
`endif
    run_op(8'h80, 8'h01, 1'b1, 1'b0, lat, bsy);
    check("ovf_80_m_01", ovf_o, 1);
    check("sum_80_m_01", sum_o, exp_s);

    // Start while busy must be ignored.
    @(posedge clk);
    #1;
    start_i = 1'b1; a_i = 8'h01; b_i = 8'h01; sub_i = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start_i = 1'b1; a_i = 8'h55;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_o) begin
        dones++;
        check("sum_busy_ignore", sum_o, 8'h02);
      end
      @(posedge clk);
      #1;
    end
    check("dones_busy_ignore", dones, 1);
    $display("busy-start test: dones=%0d sum=%h", dones, sum_o);

    // Reset in the middle of an operation.
    @(posedge clk);
    #1;
    start_i = 1'b1; a_i = 8'h33; b_i = 8'h11; sub_i = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_sum", sum_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    check("midrst_no_done", dones, 0);
    $display("mid-reset test: dones after reset=%0d", dones);
    run_op(8'h33, 8'h11, 1'b0, 1'b0, lat, bsy);
    check("after_rst_sum", sum_o, 8'h44);

    // Randomised operations, back-to-back and with gaps, with start/operand
    // noise while busy; the per-cycle compare does the checking.
    for (int n = 0; n < 150; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1, lat, bsy);
      check("rand_lat", lat, W + 1);
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
